// File: rtl/alu_sequencer.sv
// Multi-byte ALU sequencer: drives a shared 8-bit combinational ALU one byte
// per clock (LSB first), chaining carry, and assembles a W-bit result plus flags.
module alu_sequencer #(
  parameter  int NBYTES = 2,
  localparam int W      = 8 * NBYTES,
  localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [7:0]   op,
  input  logic         cin,
  input  logic [W-1:0] opa,
  input  logic [W-1:0] opb,
  output logic         busy,
  output logic         valid,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         overflow,
  output logic         zero,
  output logic         cmp,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  output logic [7:0]   alu_cins,
  output logic         alu_oe,
  output logic         alu_carryin,
  input  logic [7:0]   alu_out,
  input  logic         alu_carryout,
  input  logic         alu_overout,
  input  logic         alu_cmpo
);

  // Handshake: start is accepted only in IDLE; busy is high while the ALU is
  // driven; valid rises one cycle after the final byte and holds until the
  // next accepted start.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  state_t                  state;
  logic [IW-1:0]           idx;
  logic [NBYTES-1:0][7:0]  a_q;
  logic [NBYTES-1:0][7:0]  b_q;
  logic [NBYTES-1:0][7:0]  res_q;
  logic [7:0]              op_q;
  logic                    cin_q;
  logic                    creg;

  assign result      = res_q;
  assign busy        = (state == RUN);
  assign alu_oe      = busy;
  assign alu_cins    = op_q;
  assign alu_a       = busy ? a_q[idx] : 8'h00;
  assign alu_b       = busy ? b_q[idx] : 8'h00;
  assign alu_carryin = busy & ((idx == '0) ? cin_q : creg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      op_q     <= 8'h00;
      cin_q    <= 1'b0;
      creg     <= 1'b0;
      valid    <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
      cmp      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= opa;
            b_q   <= opb;
            op_q  <= op;
            cin_q <= cin;
            valid <= 1'b0;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          res_q[idx] <= alu_out;
          creg       <= alu_carryout;
          if (idx == LAST) begin
            carry    <= alu_carryout;
            overflow <= alu_overout;
            cmp      <= alu_cmpo;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          valid <= 1'b1;
          zero  <= (res_q == '0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer (NBYTES=2) with a behavioural adder ALU
// and a result/flag scoreboard filled at stimulus time.
module tb_alu_sequencer;
  localparam int NB = 2;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [7:0]   op;
  logic         cin;
  logic [W-1:0] opa, opb;
  logic         busy, valid, carry, overflow, zero, cmp;
  logic [W-1:0] result;
  logic [7:0]   alu_a, alu_b, alu_cins, alu_out;
  logic         alu_oe, alu_carryin, alu_carryout, alu_overout, alu_cmpo;

  logic [W-1:0] exp_q[$];
  logic [3:0]   flag_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .cin(cin),
    .opa(opa), .opb(opb), .busy(busy), .valid(valid), .result(result),
    .carry(carry), .overflow(overflow), .zero(zero), .cmp(cmp),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cins(alu_cins), .alu_oe(alu_oe),
    .alu_carryin(alu_carryin), .alu_out(alu_out), .alu_carryout(alu_carryout),
    .alu_overout(alu_overout), .alu_cmpo(alu_cmpo)
  );

  // Behavioural ALU: add with carry, signed overflow from sign bits, equality compare.
  always_comb begin
    {alu_carryout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_carryin};
    alu_overout = (alu_a[7] == alu_b[7]) && (alu_out[7] != alu_a[7]);
    alu_cmpo    = (alu_a == alu_b);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [7:0] o, input bit disturb);
    logic [W:0]   sum;
    logic [8:0]   lo;
    logic         ovf;
    logic [W-1:0] er;
    logic [3:0]   ef;
    bit           got;
    sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    lo  = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'h00, c};
    ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
    exp_q.push_back(sum[W-1:0]);
    flag_q.push_back({sum[W], ovf, (sum[W-1:0] == '0), (a[15:8] == b[15:8])});

    @(negedge clk);
    opa = a; opb = b; cin = c; op = o; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("byte0_busy", busy, 1);
    check("byte0_valid", valid, 0);
    check("byte0_oe", alu_oe, 1);
    check("byte0_a", alu_a, a[7:0]);
    check("byte0_b", alu_b, b[7:0]);
    check("byte0_cin", alu_carryin, c);
    check("byte0_cins", alu_cins, o);
    @(negedge clk);
    if (disturb) begin
      start = 1'b1; opa = ~a; opb = ~b; cin = ~c; op = ~o;
    end
    check("byte1_a", alu_a, a[15:8]);
    check("byte1_b", alu_b, b[15:8]);
    check("byte1_cin", alu_carryin, lo[8]);
    check("byte1_cins", alu_cins, o);
    @(negedge clk);
    start = 1'b0;
    check("done_busy", busy, 0);
    check("done_oe", alu_oe, 0);
    check("done_a", alu_a, 0);
    check("done_cin", alu_carryin, 0);
    check("done_valid", valid, 0);
    check("done_cins", alu_cins, o);

    got = 0;
    for (int k = 4; k <= 12; k++) begin
      @(negedge clk);
      if (valid) begin
        check("latency", k, 4);
        got = 1;
        break;
      end
    end
    if (!got) check("valid_timeout", valid, 1);
    er = exp_q.pop_front();
    ef = flag_q.pop_front();
    check("result", result, er);
    check("carry", carry, ef[3]);
    check("overflow", overflow, ef[2]);
    check("zero", zero, ef[1]);
    check("cmp", cmp, ef[0]);
    @(negedge clk);
    check("no_restart", busy, 0);
    check("valid_held", valid, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 8'h00; cin = 1'b0; opa = '0; opb = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {carry, overflow, zero, cmp}, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_cins", alu_cins, 0);
    check("rst_oe", alu_oe, 0);
    check("rst_carryin", alu_carryin, 0);
    rst = 1'b0;

    run_op(16'h12FF, 16'h0001, 1'b0, 8'h01, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 8'h02, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 8'h03, 0);
    run_op(16'h0001, 16'h0001, 1'b0, 8'h04, 0);
    run_op(16'h00FF, 16'h0000, 1'b1, 8'h05, 0);
    run_op(16'h1234, 16'h4321, 1'b0, 8'h06, 1);

    // Reset during the second RUN cycle.
    @(negedge clk);
    opa = 16'hAAAA; opb = 16'h5555; cin = 1'b0; op = 8'h0A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_valid", valid, 0);
    check("rstmid_result", result, 0);
    @(negedge clk);
    check("rstmid_busy2", busy, 0);
    check("rstmid_result2", result, 0);
    check("rstmid_flags", {carry, overflow, zero, cmp}, 0);
    rst = 1'b0;

    run_op(16'h0F0F, 16'hF0F1, 1'b0, 8'h07, 0);
    for (int i = 0; i < 6; i++) begin
      run_op(W'($urandom_range(0, 16'hFFFF)), W'($urandom_range(0, 16'hFFFF)),
             1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not complete");
  end

endmodule
